// File: rtl/regfile_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | regfile_port_arbiter: round-robin core/debug arbiter and sequencer for the  |
// | shared register-file port. Optional: REGFILE_ARB_R0_PROTECT_EN.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module regfile_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_wen,
  input  logic [DATA_W-1:0] rf_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       c_owner_core = 1'b0;
  localparam logic       c_owner_dbg  = 1'b1;
  localparam logic [3:0] c_rd_lat     = 4'(RD_LAT);
`ifdef REGFILE_ARB_R0_PROTECT_EN
  localparam logic       c_r0_protect = 1'b1;
`else
  localparam logic       c_r0_protect = 1'b0;
`endif

  state_t      r_state, w_state;
  logic        r_owner, w_owner;
  logic        r_last_owner, w_last_owner;
  logic        r_we, w_we;
  logic [3:0]  r_cnt, w_cnt;

  logic              w_core_gnt, w_dbg_gnt, w_rvalid, w_rf_wen, w_busy;
  logic [DATA_W-1:0] w_rdata, w_rf_din;
  logic [ADDR_W-1:0] w_rf_addr;
  logic              w_win_dbg, w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Debug wins when alone, or on a tie when core owned the port last.
  assign w_win_dbg   = dbg_req && (!core_req || (r_last_owner == c_owner_core));
  assign w_sel_we    = w_win_dbg ? dbg_we    : core_we;
  assign w_sel_addr  = w_win_dbg ? dbg_addr  : core_addr;
  assign w_sel_wdata = w_win_dbg ? dbg_wdata : core_wdata;

  // Outputs are registered, so each state's outputs are prepared on entry.
  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_owner = r_last_owner;
    w_we         = r_we;
    w_cnt        = r_cnt;
    w_core_gnt   = 1'b0;
    w_dbg_gnt    = 1'b0;
    w_rvalid     = 1'b0;
    w_rf_wen     = 1'b0;
    w_rdata      = rdata;
    w_rf_addr    = rf_addr;
    w_rf_din     = rf_din;
    case (r_state)
      IDLE: begin
        if (core_req || dbg_req) begin
          w_owner      = w_win_dbg;
          w_last_owner = w_win_dbg;
          w_we         = w_sel_we;
          w_rf_addr    = w_sel_addr;
          if (w_sel_we) begin
            w_rf_din = w_sel_wdata;
            w_rf_wen = !(c_r0_protect && (w_sel_addr == '0));
          end
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_core_gnt = (r_owner == c_owner_core);
          w_dbg_gnt  = (r_owner == c_owner_dbg);
          w_state    = RESP;
        end else begin
          w_cnt   = c_rd_lat;
          w_state = WAIT;
        end
      end
      WAIT: begin
        w_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_rdata    = rf_dout;
          w_rvalid   = 1'b1;
          w_core_gnt = (r_owner == c_owner_core);
          w_dbg_gnt  = (r_owner == c_owner_dbg);
          w_state    = RESP;
        end
      end
      RESP: w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= c_owner_core;
      r_last_owner <= c_owner_dbg;
      r_we         <= 1'b0;
      r_cnt        <= 4'd0;
      core_gnt     <= 1'b0;
      dbg_gnt      <= 1'b0;
      rvalid       <= 1'b0;
      rf_wen       <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      rf_addr      <= '0;
      rf_din       <= '0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_owner <= w_last_owner;
      r_we         <= w_we;
      r_cnt        <= w_cnt;
      core_gnt     <= w_core_gnt;
      dbg_gnt      <= w_dbg_gnt;
      rvalid       <= w_rvalid;
      rf_wen       <= w_rf_wen;
      busy         <= w_busy;
      rdata        <= w_rdata;
      rf_addr      <= w_rf_addr;
      rf_din       <= w_rf_din;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_regfile_port_arbiter: scoreboard bench for regfile_port_arbiter.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_port_arbiter;

  localparam int RD_LAT = 1;
`ifdef REGFILE_ARB_R0_PROTECT_EN
  localparam bit c_r0p = 1'b1;
`else
  localparam bit c_r0p = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [3:0]  core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        core_gnt, dbg_gnt, rvalid, rf_wen, busy;
  logic [15:0] rdata, rf_din, rf_dout;
  logic [3:0]  rf_addr;

  regfile_port_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .rdata(rdata), .rvalid(rvalid),
    .rf_addr(rf_addr), .rf_din(rf_din), .rf_wen(rf_wen), .rf_dout(rf_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Physical register file driven only by the DUT's port.
  logic [15:0] mem [16];
  always @(posedge clk) if (rf_wen) mem[rf_addr] <= rf_din;
  assign rf_dout = mem[rf_addr];

  // Reference model: architectural register contents, updated in request order.
  logic [15:0] model [16];

  typedef struct { logic rd; logic [15:0] data; } exp_t;
  exp_t core_q[$];
  exp_t dbg_q[$];
  int   order_q[$];
  int   gcyc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_count = 0;
  logic prev_wen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int who);
    exp_t e;
    if ((who == 0 && core_q.size() == 0) || (who == 1 && dbg_q.size() == 0)) begin
      chk(who == 0 ? "unexpected_core_gnt" : "unexpected_dbg_gnt", 1, 0);
    end else begin
      e = (who == 0) ? core_q.pop_front() : dbg_q.pop_front();
      chk(who == 0 ? "core_rvalid" : "dbg_rvalid", {31'd0, rvalid}, {31'd0, e.rd});
      if (e.rd) chk(who == 0 ? "core_rdata" : "dbg_rdata", {16'd0, rdata}, {16'd0, e.data});
      chk("busy_at_gnt", {31'd0, busy}, 1);
      order_q.push_back(who);
      gcyc_q.push_back(cyc);
    end
  endtask

  // Monitor: compares every grant against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (core_gnt && dbg_gnt) chk("dual_gnt", 1, 0);
    if (rvalid && !core_gnt && !dbg_gnt) chk("rvalid_without_gnt", 1, 0);
    if (core_gnt) pop_check(0);
    if (dbg_gnt) pop_check(1);
    if (rf_wen) begin
      wen_count++;
      chk("wen_single_cycle", {31'd0, prev_wen}, 0);
      if (c_r0p) chk("r0_protect_wen", {28'd0, rf_addr} == 0 ? 1 : 0, 0);
    end
    prev_wen = rf_wen;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drop(input int who);
    if (who == 0) core_req = 1'b0; else dbg_req = 1'b0;
  endtask

  // Issue one request and hold it until its grant (bounded).
  task automatic xact(input int who, input logic we, input logic [3:0] a,
                      input logic [15:0] d, output int lat);
    exp_t e;
    e.rd = !we;
    e.data = model[a];
    if (we && !(c_r0p && a == 4'd0)) model[a] = d;
    if (who == 0) begin
      core_q.push_back(e);
      core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    end else begin
      dbg_q.push_back(e);
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!((who == 0) ? core_gnt : dbg_gnt) && lat < 200);
    if (lat >= 200) chk("gnt_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic rand_traffic(input int who, input int n);
    int lat;
    logic [3:0] a;
    for (int i = 0; i < n; i++) begin
      a = 4'($urandom_range(0, 7)) + ((who == 1) ? 4'd8 : 4'd0);
      xact(who, 1'($urandom_range(0, 1)), a, 16'($urandom), lat);
      if ($urandom_range(0, 2) == 0) begin
        drop(who);
        tick($urandom_range(1, 3));
      end
    end
    drop(who);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, w0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; model[i] = '0; end

    // Reset state
    tick(2);
    chk("rst_core_gnt", {31'd0, core_gnt}, 0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rdata", {16'd0, rdata}, 0);
    chk("rst_rf_addr", {28'd0, rf_addr}, 0);
    chk("rst_rf_din", {16'd0, rf_din}, 0);
    rst_n = 1'b1;
    tick(2);

    // Core write alone, issue-cycle port values checked directly
    core_q.push_back('{rd: 1'b0, data: 16'h0});
    model[5] = 16'h1234;
    core_req = 1'b1; core_we = 1'b1; core_addr = 4'h5; core_wdata = 16'h1234;
    tick(1);
    chk("wr_rf_wen", {31'd0, rf_wen}, 1);
    chk("wr_rf_addr", {28'd0, rf_addr}, 5);
    chk("wr_rf_din", {16'd0, rf_din}, 16'h1234);
    chk("wr_busy", {31'd0, busy}, 1);
    tick(1);
    chk("wr_core_gnt", {31'd0, core_gnt}, 1);
    chk("wr_rvalid", {31'd0, rvalid}, 0);
    drop(0);
    tick(2);

    // Debug read of a preloaded register
    mem[2] = 16'hc61b; model[2] = 16'hc61b;
    w0 = wen_count;
    xact(1, 1'b0, 4'h2, 16'h0, lat);
    chk("rd_latency", lat, 2 + RD_LAT);
    drop(1);
    tick(2);
    chk("rd_no_wen", wen_count, w0);

    // Tie after reset: core first, then strict alternation
    pulse_reset();
    order_q.delete(); gcyc_q.delete();
    fork
      begin xact(0, 1'b0, 4'h1, 16'h0, lat); xact(0, 1'b0, 4'h1, 16'h0, lat); drop(0); end
      begin xact(1, 1'b0, 4'h3, 16'h0, lat2); xact(1, 1'b0, 4'h3, 16'h0, lat2); drop(1); end
    join
    tick(3);
    chk("tie_count", order_q.size(), 4);
    if (order_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("tie_order", order_q[i], i % 2);
      for (int i = 1; i < 4; i++) chk("tie_spacing", gcyc_q[i] - gcyc_q[i-1], 3 + RD_LAT);
    end
    chk("tie_idle_busy", {31'd0, busy}, 0);

    // Write then cross-requester read
    xact(0, 1'b1, 4'hA, 16'hbeef, lat);
    chk("wr_latency", lat, 2);
    drop(0);
    tick(1);
    xact(1, 1'b0, 4'hA, 16'h0, lat);
    drop(1);
    tick(2);

    // Reset in the middle of a read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h5;
    tick(2);
    chk("midrst_busy_before", {31'd0, busy}, 1);
    chk("midrst_addr_before", {28'd0, rf_addr}, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_rf_addr", {28'd0, rf_addr}, 0);
    chk("midrst_gnt", {30'd0, core_gnt, dbg_gnt}, 0);
    chk("midrst_rvalid", {31'd0, rvalid}, 0);
    dbg_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    xact(1, 1'b0, 4'h5, 16'h0, lat);
    chk("post_rst_latency", lat, 2 + RD_LAT);
    drop(1);
    tick(2);

    // Register 0 write and readback
    w0 = wen_count;
    xact(0, 1'b1, 4'h0, 16'hffff, lat);
    chk("r0_wr_latency", lat, 2);
    drop(0);
    tick(2);
    chk("r0_wen_count", wen_count - w0, c_r0p ? 0 : 1);
    xact(1, 1'b0, 4'h0, 16'h0, lat);
    drop(1);
    tick(2);

    // Randomized concurrent traffic on disjoint address halves
    fork
      rand_traffic(0, 60);
      rand_traffic(1, 60);
    join
    tick(6);
    chk("core_q_empty", core_q.size(), 0);
    chk("dbg_q_empty", dbg_q.size(), 0);
    chk("final_busy", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
